// File: rtl/scr1_clk_gate_ctrl_if.sv
// Handshake bundle between the pipeline/bus side and the clock-gate controller.
// The master drives the sleep, wake and bus-status levels. The slave is the
// controller, and it returns the clock-gate enable and the status flags.
interface scr1_clk_gate_ctrl_if;
    logic clk_ctrl_en;  // global gating enable; 0 forces the clock on
    logic sleep_req;    // WFI retired, level
    logic wake_irq;     // pending enabled interrupt, level
    logic wake_dbg;     // debug halt request, level
    logic bus_busy;     // outstanding IFU/LSU transaction(s)
    logic clk_en;       // to clock-gate cell; 0 gates the core clock
    logic core_sleep;   // high while the clock is gated
    logic wake_done;    // one-cycle pulse when the core is released after wake

    modport master (
        output clk_ctrl_en,
        output sleep_req,
        output wake_irq,
        output wake_dbg,
        output bus_busy,
        input  clk_en,
        input  core_sleep,
        input  wake_done
    );

    modport slave (
        input  clk_ctrl_en,
        input  sleep_req,
        input  wake_irq,
        input  wake_dbg,
        input  bus_busy,
        output clk_en,
        output core_sleep,
        output wake_done
    );
endinterface

// File: rtl/scr1_clk_gate_ctrl.sv
// Sleep/wake controller feeding the core clock-gate enable.
// This block runs on the free-running clock. A sleep request first waits for
// the bus to drain and then for a run of idle cycles before the core clock is
// gated. A wake event restores the clock at once. The core is released only
// after a fixed settle window, and wake_done pulses at that moment.
module scr1_clk_gate_ctrl #(
    parameter int unsigned IDLE_CYCLES = 4,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    scr1_clk_gate_ctrl_if.slave  ctrl
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_SLEEP = 2'd2;
    localparam logic [1:0] ST_WAKE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wake_done_q;
    logic             wake_done_d;
    logic             wake_s;

    assign wake_s = ctrl.wake_irq | ctrl.wake_dbg;

    // Next-state and counter logic. The counter only ever moves toward its
    // compare value, so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (ctrl.clk_ctrl_en & ctrl.sleep_req & ~wake_s) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_DRAIN: begin
                if (wake_s | ~ctrl.sleep_req | ~ctrl.clk_ctrl_en) begin
                    // Abort: the request went away or a wake arrived first.
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                end else if (ctrl.bus_busy) begin
                    // Any traffic restarts the idle window.
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == IDLE_LAST) begin
                    state_d = ST_SLEEP;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_DRAIN;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_SLEEP: begin
                // sleep_req is stale here because the core is frozen.
                if (wake_s | ~ctrl.clk_ctrl_en) begin
                    state_d = ST_WAKE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_SLEEP;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_WAKE: begin
                // The settle window always runs to completion.
                if (cnt_q == WAKE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_WAKE;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Release pulse: set on the WAKE to RUN transition, so it is high in the
    // first RUN cycle.
    always_comb begin
        if ((state_q == ST_WAKE) && (cnt_q == WAKE_LAST)) begin
            wake_done_d = 1'b1;
        end else begin
            wake_done_d = 1'b0;
        end
    end

    // State, counter and pulse registers. Reset returns to RUN with the clock on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= CNT_ZERO;
            wake_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wake_done_q <= wake_done_d;
        end
    end

    assign ctrl.clk_en     = (state_q != ST_SLEEP);
    assign ctrl.core_sleep = (state_q == ST_SLEEP);
    assign ctrl.wake_done  = wake_done_q;

endmodule

// File: tb/tb_scr1_clk_gate_ctrl.sv
// Testbench for scr1_clk_gate_ctrl (IDLE_CYCLES=4, WAKE_CYCLES=2).
// The bench runs directed vector tables, a few hand-written corner sequences,
// and randomized traffic that is checked against a behavioural model.
module tb_scr1_clk_gate_ctrl;

    localparam int IDLE_CYCLES = 4;
    localparam int WAKE_CYCLES = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    scr1_clk_gate_ctrl_if bus ();

    scr1_clk_gate_ctrl #(
        .IDLE_CYCLES (IDLE_CYCLES),
        .WAKE_CYCLES (WAKE_CYCLES),
        .CNT_W       (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic en;
        logic req;
        logic irq;
        logic dbg;
        logic busy;
        logic exp_clk_en;
        logic exp_sleep;
        logic exp_done;
    } vec_t;

    vec_t vecs [28];

    // Behavioural model state. It records whether the core is gated, whether
    // a drain is in progress, the current idle streak and the remaining wake
    // settle cycles.
    bit m_gated;
    bit m_draining;
    int m_streak;
    int m_wake_left;
    bit m_done;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic e_en, input logic e_sl, input logic e_dn);
        check({name, ".clk_en"}, bus.clk_en, e_en);
        check({name, ".core_sleep"}, bus.core_sleep, e_sl);
        check({name, ".wake_done"}, bus.wake_done, e_dn);
    endtask

    task automatic drive(input logic en, input logic req, input logic irq, input logic dbg, input logic busy);
        bus.clk_ctrl_en = en;
        bus.sleep_req   = req;
        bus.wake_irq    = irq;
        bus.wake_dbg    = dbg;
        bus.bus_busy    = busy;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_gated     = 1'b0;
        m_draining  = 1'b0;
        m_streak    = 0;
        m_wake_left = 0;
        m_done      = 1'b0;
    endtask

    // One clock edge of the model, using the inputs that are present at the edge.
    task automatic model_step(input bit en, input bit req, input bit irq, input bit dbg, input bit busy);
        bit wake;
        wake   = irq | dbg;
        m_done = 1'b0;
        if (m_wake_left > 0) begin
            m_wake_left--;
            if (m_wake_left == 0) m_done = 1'b1;
        end else if (m_gated) begin
            if (wake || !en) begin
                m_gated     = 1'b0;
                m_wake_left = WAKE_CYCLES;
            end
        end else if (m_draining) begin
            if (wake || !req || !en) begin
                m_draining = 1'b0;
            end else if (busy) begin
                m_streak = 0;
            end else begin
                m_streak++;
                if (m_streak == IDLE_CYCLES) begin
                    m_draining = 1'b0;
                    m_gated    = 1'b1;
                end
            end
        end else if (en && req && !wake) begin
            m_draining = 1'b1;
            m_streak   = 0;
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_vec(input int i, input logic en, input logic req, input logic irq, input logic dbg,
                           input logic busy, input logic e_en, input logic e_sl, input logic e_dn);
        vecs[i].en = en;   vecs[i].req = req;  vecs[i].irq = irq;
        vecs[i].dbg = dbg; vecs[i].busy = busy;
        vecs[i].exp_clk_en = e_en; vecs[i].exp_sleep = e_sl; vecs[i].exp_done = e_dn;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Each vector is applied for one clock edge. The outputs are compared after that edge.
        //            en   req  irq  dbg  busy  clk_en sleep done
        set_vec( 0, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
        set_vec( 1, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0); // -> DRAIN
        set_vec( 2, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
        set_vec( 3, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
        set_vec( 4, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
        set_vec( 5, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0); // gated 4 idle edges later
        set_vec( 6, 1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0); // stale req drop and busy ignored
        set_vec( 7, 1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0); // irq -> WAKE, clock back on
        set_vec( 8, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
        set_vec( 9, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1); // RUN + wake_done
        set_vec(10, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0); // pulse is one cycle
        set_vec(11, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0); // -> DRAIN
        set_vec(12, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
        set_vec(13, 1'b1,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0); // busy restarts the window
        set_vec(14, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
        set_vec(15, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
        set_vec(16, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
        set_vec(17, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0); // gated late
        set_vec(18, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0); // enable drop -> WAKE
        set_vec(19, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
        set_vec(20, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1); // RUN + wake_done
        set_vec(21, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0); // gating disabled: stay RUN
        set_vec(22, 1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0); // req with wake: stay RUN
        set_vec(23, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0); // -> DRAIN cnt 0
        set_vec(24, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0); // cnt 1
        set_vec(25, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0); // cnt 2
        set_vec(26, 1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0); // dbg abort, no pulse
        set_vec(27, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);

        do_reset();
        @(negedge clk);
        check_outs("reset", 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 28; i++) begin
            drive(vecs[i].en, vecs[i].req, vecs[i].irq, vecs[i].dbg, vecs[i].busy);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].exp_clk_en, vecs[i].exp_sleep, vecs[i].exp_done);
        end

        // With gating disabled, a held sleep request must never gate the clock.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            tick();
            check_outs("gate_off_hold", 1'b1, 1'b0, 1'b0);
        end

        // An asynchronous reset during SLEEP must restore the clock without waiting for an edge.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1 + IDLE_CYCLES; i++) tick();
        check_outs("pre_async_sleep", 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.clk_en", bus.clk_en, 1'b1);
        check("async_rst.core_sleep", bus.core_sleep, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_outs("post_rst_req_wake", 1'b1, 1'b0, 1'b0);
        end

        // Randomized traffic checked against the behavioural model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit en, req, irq, dbg, busy;
            en   = ($urandom_range(0, 15) != 0);
            req  = ($urandom_range(0, 7) != 0);
            irq  = ($urandom_range(0, 19) == 0);
            dbg  = ($urandom_range(0, 39) == 0);
            busy = ($urandom_range(0, 3) == 0);
            drive(en, req, irq, dbg, busy);
            model_step(en, req, irq, dbg, busy);
            tick();
            check_outs("random", !m_gated, m_gated, m_done);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scr1_clk_gate_ctrl.md
Name: scr1_clk_gate_ctrl

Overview:
- Sleep/wake controller that drives the `clk_en` input of the core clock-gate cell.
- Accepts a WFI-style sleep request from the pipeline and waits until bus traffic has drained and stayed idle for a hysteresis window, then gates the core clock.
- Restores the clock on an interrupt or debug wake event, and releases the core only after a wake settle window.
- Runs on the free-running (ungated) clock, directly upstream of the clock gate.

Parameters:
- IDLE_CYCLES, 4: consecutive bus-idle cycles required in DRAIN before gating; legal range ≥1.
- WAKE_CYCLES, 2: cycles clk_en is held high in WAKE before returning to RUN; legal range ≥1.
- CNT_W, 4: counter width; must hold max(IDLE_CYCLES, WAKE_CYCLES)-1.

Ports:
- clk  input  1  free-running core clock (ungated).
- rst  input  1  asynchronous reset, active-high.
- clk_ctrl_en  input  1  global gating enable; 0 forces the clock on.
- sleep_req  input  1  level request from pipeline (WFI retired).
- wake_irq  input  1  pending enabled interrupt (level).
- wake_dbg  input  1  debug halt request (level).
- bus_busy  input  1  outstanding IFU/LSU transaction(s).
- clk_en  output  1  to clock-gate cell; 0 gates the core clock.
- core_sleep  output  1  high while the clock is gated.
- wake_done  output  1  one-cycle pulse when the core is released after wake.

Behaviour:
- Moore FSM; all outputs registered or decoded from the state register. States: RUN, DRAIN, SLEEP, WAKE. Single counter cnt[CNT_W-1:0].
- Reset (async, rst=1): state=RUN, cnt=0, clk_en=1, core_sleep=0, wake_done=0.
- Output decode: clk_en = (state!=SLEEP); core_sleep = (state==SLEEP).
- wake = wake_irq | wake_dbg.
- RUN:
  - clk_ctrl_en & sleep_req & ~wake -> DRAIN, cnt=0.
  - Sleep request together with wake in the same cycle -> stay in RUN.
- DRAIN, priority order:
  - (a) wake | ~sleep_req | ~clk_ctrl_en -> RUN (abort; no wake_done pulse).
  - (b) bus_busy -> cnt=0, stay.
  - (c) idle and cnt==IDLE_CYCLES-1 -> SLEEP.
  - (d) otherwise cnt++.
  - Busy in any cycle restarts the idle window; wake has priority over idle completion in the same cycle.
- SLEEP:
  - wake | ~clk_ctrl_en -> WAKE, cnt=0.
  - sleep_req deassertion alone does not wake (the core is frozen, so the value is stale). bus_busy is ignored.
- WAKE:
  - cnt==WAKE_CYCLES-1 -> RUN; otherwise cnt++.
  - Wake inputs are ignored; the window always completes.
- wake_done: registered, high exactly in the first RUN cycle after WAKE; never asserted on a DRAIN abort.
- Latency:
  - sleep_req seen in RUN at cycle N with bus idle -> clk_en=0 at cycle N+1+IDLE_CYCLES.
  - Wake seen in SLEEP at cycle M -> clk_en=1 at M+1, RUN and wake_done at M+1+WAKE_CYCLES.
- clk_ctrl_en=0: the FSM never leaves RUN/WAKE toward SLEEP, so clk_en stays high.
- Reset mid-sleep: immediately forces clk_en=1 and state RUN.
- Counter: never wraps; bounded by the compare values.

Test Plan:
- Reset, then IDLE_CYCLES=4, bus idle, sleep_req=1 at cycle 10 -> DRAIN at 11; clk_en=0 and core_sleep=1 at 15.
- As above, but bus_busy=1 at cycle 13 only -> cnt restarts; clk_en falls at 18.
- In SLEEP, wake_irq=1 at cycle 20, WAKE_CYCLES=2 -> clk_en=1 at 21; RUN and wake_done=1 at 23 only; core_sleep=0 from 21.
- In DRAIN (cnt=2), wake_dbg=1 -> RUN next cycle; clk_en never drops; wake_done stays 0.
- clk_ctrl_en=0 with sleep_req=1 held for 50 cycles -> clk_en constantly 1, state RUN. Deassert clk_ctrl_en while in SLEEP -> WAKE, then RUN with wake_done.
- rst=1 asynchronously mid-SLEEP -> clk_en=1 and core_sleep=0 without waiting for a clock edge; after release, sleep_req=1 with a simultaneous wake_irq=1 in RUN -> stays RUN.
